// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU datapath constants and types
package alu_pkg;

  localparam int DATA_W    = 16;
  localparam int SEL_BITS  = 2;
  localparam int NUM_UNITS = 2 ** SEL_BITS;

  typedef logic [DATA_W-1:0]   alu_word_t;
  typedef logic [SEL_BITS-1:0] unit_idx_t;

endpackage

// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - combinational round-robin arbiter over unit slots
module alu_rr_arbiter #(
  parameter int REQ_SEL = alu_pkg::SEL_BITS,
  parameter int REQ_NUM = 2 ** REQ_SEL
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_SEL-1:0] last_grant,
  output logic [REQ_SEL-1:0] grant,
  output logic               any_req
);

  logic [REQ_SEL-1:0] idx;
  logic               found;

  // Search starts one past the previous winner; index arithmetic wraps naturally.
  always_comb begin
    grant   = last_grant;
    any_req = |req;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      idx = last_grant + REQ_SEL'(k);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_result_collector.sv
// rtl/alu_result_collector.sv - merges ALU unit results into one registered stream
module alu_result_collector #(
  parameter int DATA_W   = alu_pkg::DATA_W,
  parameter int SEL_BITS = alu_pkg::SEL_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [(2**SEL_BITS)*DATA_W-1:0] res_data,
  input  logic [(2**SEL_BITS)-1:0]        res_valid,
  output logic [(2**SEL_BITS)-1:0]        res_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic [SEL_BITS-1:0]             out_unit,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [SEL_BITS:0]               pending
);

  localparam int NUM_UNITS = 2 ** SEL_BITS;

  logic [NUM_UNITS-1:0] slot_valid;
  logic [DATA_W-1:0]    slot_data [NUM_UNITS];
  logic [SEL_BITS-1:0]  last_grant;
  logic [SEL_BITS-1:0]  grant;
  logic                 any_req;
  logic [NUM_UNITS-1:0] capture;
  logic                 load;
  logic                 out_hs;
  logic [SEL_BITS:0]    cap_cnt;
  logic [SEL_BITS:0]    pending_next;

  alu_rr_arbiter #(
    .REQ_SEL (SEL_BITS),
    .REQ_NUM (NUM_UNITS)
  ) u_arb (
    .req        (slot_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any_req    (any_req)
  );

  // Ready depends only on slot occupancy, so there is no path from out_ready.
  assign res_ready = ~slot_valid;
  assign capture   = res_valid & ~slot_valid;
  assign load      = any_req & (~out_valid | out_ready);
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    cap_cnt = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      cap_cnt = cap_cnt + (SEL_BITS+1)'(capture[i]);
    end
    pending_next = pending + cap_cnt - (SEL_BITS+1)'(out_hs);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (capture[i]) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= res_data[i*DATA_W +: DATA_W];
        end else if (load && (grant == SEL_BITS'(i))) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Reset to the top index so unit 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_unit   <= '0;
      last_grant <= SEL_BITS'(NUM_UNITS - 1);
      pending    <= '0;
    end else begin
      pending <= pending_next;
      if (load) begin
        out_valid  <= 1'b1;
        out_data   <= slot_data[grant];
        out_unit   <= grant;
        last_grant <= grant;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// tb/tb_alu_result_collector.sv - directed self-checking bench for alu_result_collector
module tb_alu_result_collector;

  logic        clk;
  logic        rst_n;
  logic [63:0] res_data;
  logic [3:0]  res_valid;
  logic [3:0]  res_ready;
  logic [15:0] out_data;
  logic [1:0]  out_unit;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  pending;

  int tests_run;
  int tests_failed;

  alu_result_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .out_data  (out_data),
    .out_unit  (out_unit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    res_valid = '0;
    res_data  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    res_valid = '0;
    res_data  = '0;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_unit !== 2'd0 ||
        res_ready !== 4'b1111 || pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: ov=%b od=%h ou=%0d rr=%b pend=%0d, want 0 0000 0 1111 0",
               out_valid, out_data, out_unit, res_ready, pending);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b0 || res_ready !== 4'b1111 || pending !== 3'd0) begin
        tests_failed++;
        $display("FAIL reset_idle[%0d]: ov=%b rr=%b pend=%0d, want 0 1111 0",
                 i, out_valid, res_ready, pending);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready       = 1'b1;
    res_data[47:32] = 16'h1234;
    res_valid       = 4'b0100;
    tick();
    res_valid = '0;
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_capture: ov=%b pend=%0d, want 0 1", out_valid, pending);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_unit !== 2'd2 || pending !== 3'd1) begin
      tests_failed++;
      $display("FAIL single_out: ov=%b od=%h ou=%0d pend=%0d, want 1 1234 2 1",
               out_valid, out_data, out_unit, pending);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 3'd0 || out_data !== 16'h1234) begin
      tests_failed++;
      $display("FAIL single_drain: ov=%b pend=%0d od=%h, want 0 0 1234 (held)",
               out_valid, pending, out_data);
    end
  endtask

  task automatic test_burst();
    do_reset();
    out_ready = 1'b1;
    res_data  = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    res_valid = 4'b1111;
    tick();
    res_valid = '0;
    tests_run++;
    if (pending !== 3'd4 || res_ready !== 4'b0000 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL burst_capture: pend=%0d rr=%b ov=%b, want 4 0000 0", pending, res_ready, out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_unit !== 2'(k) || out_data !== 16'(10 + k) ||
          pending !== 3'(4 - k)) begin
        tests_failed++;
        $display("FAIL burst_out[%0d]: ov=%b ou=%0d od=%h pend=%0d, want 1 %0d %h %0d",
                 k, out_valid, out_unit, out_data, pending, k, 16'(10 + k), 4 - k);
      end
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL burst_end: ov=%b pend=%0d, want 0 0", out_valid, pending);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready       = 1'b0;
    res_data[31:16] = 16'h1111;
    res_data[63:48] = 16'h3333;
    res_valid       = 4'b1010;
    tick();
    res_valid = '0;
    tests_run++;
    if (pending !== 3'd2) begin
      tests_failed++;
      $display("FAIL bp_capture: pend=%0d, want 2", pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_unit !== 2'd1 || out_data !== 16'h1111 ||
          res_ready !== 4'b0111 || pending !== 3'd2) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: ov=%b ou=%0d od=%h rr=%b pend=%0d, want 1 1 1111 0111 2",
                 i, out_valid, out_unit, out_data, res_ready, pending);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_unit !== 2'd3 || out_data !== 16'h3333 || pending !== 3'd1) begin
      tests_failed++;
      $display("FAIL bp_next: ov=%b ou=%0d od=%h pend=%0d, want 1 3 3333 1",
               out_valid, out_unit, out_data, pending);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_unit !== 2'd3 || out_data !== 16'h3333 || res_ready !== 4'b1111) begin
      tests_failed++;
      $display("FAIL bp_hold2: ov=%b ou=%0d od=%h rr=%b, want 1 3 3333 1111",
               out_valid, out_unit, out_data, res_ready);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL bp_drain: ov=%b pend=%0d, want 0 0", out_valid, pending);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_unit;
    logic [15:0] exp_data;
    do_reset();
    out_ready      = 1'b1;
    res_data[15:0] = 16'h00A0;
    res_data[31:16] = 16'h00B1;
    res_valid      = 4'b0011;
    tick();
    for (int i = 1; i < 20; i++) begin
      tick();
      exp_unit = 2'((i - 1) % 2);
      exp_data = (exp_unit == 2'd0) ? 16'h00A0 : 16'h00B1;
      tests_run++;
      if (out_valid !== 1'b1 || out_unit !== exp_unit || out_data !== exp_data) begin
        tests_failed++;
        $display("FAIL fair[%0d]: ov=%b ou=%0d od=%h, want 1 %0d %h",
                 i, out_valid, out_unit, out_data, exp_unit, exp_data);
      end
    end
    res_valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    res_data  = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
    res_valid = 4'b0111;
    tick();
    res_valid = '0;
    tick();
    tests_run++;
    if (pending !== 3'd3 || out_valid !== 1'b1 || out_unit !== 2'd0) begin
      tests_failed++;
      $display("FAIL arst_setup: pend=%0d ov=%b ou=%0d, want 3 1 0", pending, out_valid, out_unit);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || pending !== 3'd0 || res_ready !== 4'b1111 || out_data !== 16'h0) begin
      tests_failed++;
      $display("FAIL arst_immediate: ov=%b pend=%0d rr=%b od=%h, want 0 0 1111 0000",
               out_valid, pending, res_ready, out_data);
    end
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    res_data  = {16'h3003, 16'h0, 16'h0, 16'h0110};
    res_valid = 4'b1001;
    tick();
    res_valid = '0;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_unit !== 2'd0 || out_data !== 16'h0110) begin
      tests_failed++;
      $display("FAIL arst_first: ov=%b ou=%0d od=%h, want 1 0 0110", out_valid, out_unit, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_unit !== 2'd3 || out_data !== 16'h3003) begin
      tests_failed++;
      $display("FAIL arst_second: ov=%b ou=%0d od=%h, want 1 3 3003", out_valid, out_unit, out_data);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    res_valid    = '0;
    res_data     = '0;
    out_ready    = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_fairness();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
